// File: rtl/ifetch_if.sv
// Fetch-unit bus: ROM read port, redirect input and the decode-side instruction stream.
// Instruction stream: a transfer happens on a rising edge where instr_valid & instr_ready; head holds while stalled.
interface ifetch_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
);
  logic [AWIDTH-1:0] rom_addr;
  logic              rom_ready;
  logic [DWIDTH-1:0] rom_dout;
  logic              rom_valid;
  logic              redirect_valid;
  logic [AWIDTH-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DWIDTH-1:0] instr_data;
  logic [AWIDTH-1:0] instr_pc;

  modport master (
    output rom_addr, rom_ready, instr_valid, instr_data, instr_pc,
    input  rom_dout, rom_valid, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  rom_addr, rom_ready, instr_valid, instr_data, instr_pc,
    output rom_dout, rom_valid, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: PC, one-cycle-latency ROM reads, credit-limited buffer of {pc, data}.
module ifetch #(
  parameter int                 DWIDTH   = 16,
  parameter int                 AWIDTH   = 12,
  parameter int                 DEPTH    = 2,
  parameter logic [AWIDTH-1:0]  RESET_PC = '0
) (
  input  logic     clk,
  input  logic     rst,
  ifetch_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [AWIDTH-1:0] r_pc;
  logic              r_inflight;
  logic [AWIDTH-1:0] r_inflight_pc;
  logic              r_kill;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [DWIDTH-1:0] r_mem_data [DEPTH];
  logic [AWIDTH-1:0] r_mem_pc   [DEPTH];

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [CW:0]       w_used;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit includes the in-flight read, so every response has a free slot waiting.
  assign w_used  = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign w_issue = ~rst & ~bus.redirect_valid & (w_used < (CW+1)'(DEPTH));
  assign w_pop   = bus.instr_valid & bus.instr_ready;
  assign w_push  = bus.rom_valid & r_inflight & ~r_kill;

  assign bus.rom_addr    = r_pc;
  assign bus.rom_ready   = w_issue;
  assign bus.instr_valid = (r_count != '0) & ~bus.redirect_valid;
  assign bus.instr_data  = r_mem_data[r_rptr];
  assign bus.instr_pc    = r_mem_pc[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_kill        <= 1'b0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Flush wins over any response or pop landing in the same cycle.
      r_pc       <= bus.redirect_pc;
      r_kill     <= r_inflight;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_kill     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + AWIDTH'(1);
      end
      if (w_push) begin
        r_mem_data[r_wptr] <= bus.rom_dout;
        r_mem_pc[r_wptr]   <= r_inflight_pc;
        r_wptr             <= ptr_next(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_next(r_rptr);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: the requesting side of the instruction-ROM read handshake. It owns the program counter, issues one-address-per-cycle read requests to the synchronous instruction ROM, captures responses returned exactly one cycle later, and buffers them in a small FIFO. The FIFO presents a valid/ready instruction stream, with PC tags, to the decode stage. Redirects (branch/jump) flush the buffer and squash the in-flight read.

## Interface
- DWIDTH, 16, instruction width; matches ROM data width
- AWIDTH, 12, instruction address width; PC width
- DEPTH, 2, instruction buffer entries (≥2)
- RESET_PC, 0, PC loaded at reset
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- rom_addr  out  AWIDTH  read address to ROM; equals current PC
- rom_ready  out  1  read request to ROM (ROM enable); ROM samples rom_addr on this edge
- rom_dout  in  DWIDTH  ROM read data, valid in the cycle rom_valid=1
- rom_valid  in  1  ROM response strobe; registered copy of rom_ready (1-cycle latency)
- redirect_valid  in  1  load new PC, flush
- redirect_pc  in  AWIDTH  redirect target
- instr_valid  out  1  buffer head valid
- instr_ready  in  1  decode accepts head
- instr_data  out  DWIDTH  head instruction
- instr_pc  out  AWIDTH  head instruction address

## Operation
- State: pc, inflight flag, inflight_pc, kill flag, FIFO of {pc, data} with count 0..DEPTH.
- pop = instr_valid & instr_ready. instr_valid = (count != 0) & ~redirect_valid.
- Issue rule: rom_ready = ~rst & ~redirect_valid & (count + inflight − pop < DEPTH). Credit counts in-flight reads so a response always has a free slot; no overflow by construction.
- On issue: inflight ← 1, inflight_pc ← pc, pc ← pc + 1 (mod 2^AWIDTH; 2^AWIDTH−1 wraps to 0). No issue: inflight ← 0.
- Response: rom_valid & inflight & ~kill → push {inflight_pc, rom_dout}. rom_valid with inflight=0 or kill=1 → dropped. Push and pop in same cycle allowed; count unchanged.
- Redirect (priority over everything): count ← 0, pc ← redirect_pc, kill ← inflight (the response arriving next cycle is dropped), no issue, no pop. kill cleared every cycle not a redirect.
- Back-to-back redirects: last one wins; each flushes.
- instr_data/instr_pc stable while instr_valid=1 and instr_ready=0.

## Timing
- Reset values: pc=RESET_PC, rom_addr=RESET_PC, rom_ready=0, inflight=0, kill=0, count=0, instr_valid=0, FIFO storage (instr_data, instr_pc)=0.
- Reset asserted mid-operation: all state cleared immediately; any rom_valid arriving after reset release with no request outstanding is ignored.
- First cycle after reset release: rom_ready=1, rom_addr=RESET_PC. Cycle+1: rom_valid, entry pushed. Cycle+2: instr_valid=1. Request-to-instr_valid latency 2 cycles.
- Steady state with instr_ready=1 and DEPTH=2: one instruction per cycle, no bubbles.
- instr_ready=0: at most DEPTH reads outstanding+buffered; rom_ready drops to 0 once count+inflight=DEPTH; resumes the cycle a pop frees a credit (combinational instr_ready→rom_ready path).
- Redirect at cycle T: instr_valid=0 at T; rom_ready=1 with rom_addr=redirect_pc at T+1; first redirected instruction instr_valid at T+3.

## Test plan
- Reset release, instr_ready=1, ROM[i]=i+0x100 → instr stream pc 0,1,2,… data 0x100,0x101,…; first instr_valid 2 cycles after first rom_ready; one per cycle thereafter.
- Hold instr_ready=0 for 10 cycles → exactly DEPTH reads issued, rom_ready=0 thereafter, head stable at pc 0; release → pcs 0,1,2 in order, no loss or duplicate.
- Redirect to 0x080 while one read in flight and buffer holding 1 entry → in-flight response dropped, buffer empty, next rom_addr=0x080, next delivered instr_pc=0x080.
- redirect_pc=0xFFE, free-run → instr_pc 0xFFE, 0xFFF, 0x000, 0x001 (wrap).
- Redirects on two consecutive cycles (0x010 then 0x020) → no instruction from 0x010 delivered; stream resumes at 0x020.
- Assert rst with full buffer and read in flight, random rom_valid pulse after release → all outputs at reset values, stray response ignored, fetch restarts at RESET_PC.
